// File: rtl/ifetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer that fetches one word per
// handshake and redirects on taken branches. Fetch timeout is optional via IFETCH_TIMEOUT_EN.
module ifetch_unit (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_stall,
  input  logic              branch_taken,
  input  logic signed [7:0] branch_offset,
  output logic              imem_read,
  output logic [9:0]        imem_address,
  input  logic [31:0]       imem_readdata,
  input  logic              imem_busywait,
  output logic [31:0]       pc,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic              cpu_busywait,
  output logic              fetch_err
);

`ifdef IFETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, ERROR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;
`endif

  state_t state, state_nxt;
  logic   fetch_done;
  logic   accept;

  // Word offset is relative to the sequential address; modulo-2^32 wrap is intended.
  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic take,
                                          input logic signed [7:0] off);
    logic [31:0] seq;
    seq = cur + 32'd4;
    return take ? seq + {{22{off[7]}}, off, 2'b00} : seq;
  endfunction

  assign fetch_done   = (state == FETCH) && !imem_busywait;
  assign accept       = (state == HOLD) && !cpu_stall;
  assign imem_address = pc[9:0];

`ifdef IFETCH_TIMEOUT_EN
  logic [5:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      to_cnt <= 6'd0;
    else if (state_nxt == FETCH && state != FETCH)
      to_cnt <= 6'd0;
    else if (state == FETCH && imem_busywait)
      to_cnt <= to_cnt + 6'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    imem_read    = 1'b0;
    cpu_busywait = 1'b1;
    fetch_err    = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        imem_read = 1'b1;
        if (!imem_busywait)
          state_nxt = HOLD;
`ifdef IFETCH_TIMEOUT_EN
        else if (to_cnt == 6'd63)
          state_nxt = ERROR;
`endif
      end
      HOLD: begin
        cpu_busywait = 1'b0;
        if (!cpu_stall)
          state_nxt = FETCH;
      end
`ifdef IFETCH_TIMEOUT_EN
      ERROR: fetch_err = 1'b1;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Response data is only taken in FETCH, so late memory replies are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 32'd0;
      instruction <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      if (fetch_done) begin
        instruction <= imem_readdata;
        instr_valid <= 1'b1;
      end
      if (accept) begin
        pc          <= next_pc(pc, branch_taken, branch_offset);
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit; expectations are hand-derived.
module tb_ifetch_unit;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_stall = 1'b0;
  logic              branch_taken = 1'b0;
  logic signed [7:0] branch_offset = 8'sd0;
  logic              imem_read;
  logic [9:0]        imem_address;
  logic [31:0]       imem_readdata;
  logic              imem_busywait = 1'b0;
  logic [31:0]       pc;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic              cpu_busywait;
  logic              fetch_err;

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_readdata = mem[imem_address[9:2]];

  ifetch_unit dut (
    .clk(clk), .reset(reset), .cpu_stall(cpu_stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .imem_read(imem_read), .imem_address(imem_address),
    .imem_readdata(imem_readdata), .imem_busywait(imem_busywait), .pc(pc),
    .instruction(instruction), .instr_valid(instr_valid), .cpu_busywait(cpu_busywait),
    .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h0004_0005;

    // reset state
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_read", {31'b0, imem_read}, 32'h0);
    check("rst_busy", {31'b0, cpu_busywait}, 32'h1);
    check("rst_err", {31'b0, fetch_err}, 32'h0);

    // IDLE lasts one cycle, then FETCH at PC 0
    reset = 1'b0;
    tick();
    check("f0_read", {31'b0, imem_read}, 32'h1);
    check("f0_addr", {22'b0, imem_address}, 32'h0);
    check("f0_busy", {31'b0, cpu_busywait}, 32'h1);
    check("f0_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("h0_instr", instruction, 32'h0004_0005);
    check("h0_valid", {31'b0, instr_valid}, 32'h1);
    check("h0_read", {31'b0, imem_read}, 32'h0);
    check("h0_busy", {31'b0, cpu_busywait}, 32'h0);
    check("h0_pc", pc, 32'h0);
    tick();
    check("f1_pc", pc, 32'h4);
    check("f1_addr", {22'b0, imem_address}, 32'h4);
    check("f1_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    check("h1_instr", instruction, 32'h1000_0001);
    tick();
    check("f2_pc", pc, 32'h8);

    // three busy cycles at PC 8
    imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bw_busy", {31'b0, cpu_busywait}, 32'h1);
      check("bw_pc", pc, 32'h8);
      check("bw_read", {31'b0, imem_read}, 32'h1);
      check("bw_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_busywait = 1'b0;
    tick();
    check("bw_instr", instruction, 32'h1000_0002);
    check("bw_hvalid", {31'b0, instr_valid}, 32'h1);

    // walk to HOLD at 0x10, then branch back by -2 words
    tick(); tick(); tick(); tick();
    check("h10_pc", pc, 32'h10);
    branch_taken = 1'b1;
    branch_offset = 8'shFE;
    tick();
    check("brn_pc", pc, 32'h0C);
    check("brn_read", {31'b0, imem_read}, 32'h1);
    branch_taken = 1'b0;
    tick(); tick(); tick();
    check("h10b_pc", pc, 32'h10);
    check("h10b_instr", instruction, 32'h1000_0004);

    // stall with branch pulses: nothing may move
    cpu_stall = 1'b1;
    branch_offset = 8'sd3;
    for (int i = 0; i < 5; i++) begin
      branch_taken = ~branch_taken;
      tick();
      check("stl_valid", {31'b0, instr_valid}, 32'h1);
      check("stl_pc", pc, 32'h10);
      check("stl_read", {31'b0, imem_read}, 32'h0);
      check("stl_instr", instruction, 32'h1000_0004);
    end
    cpu_stall = 1'b0;
    branch_taken = 1'b1;
    tick();
    check("brp_pc", pc, 32'h20);
    branch_taken = 1'b0;
    tick();
    check("h20_instr", instruction, 32'h1000_0008);

    // 0x20 + 4 - 40 wraps below zero
    branch_taken = 1'b1;
    branch_offset = 8'shF6;
    tick();
    check("wrn_pc", pc, 32'hFFFF_FFFC);
    check("wrn_addr", {22'b0, imem_address}, 32'h3FC);
    branch_taken = 1'b0;
    tick();
    check("wrn_instr", instruction, 32'h1000_00FF);
    tick();
    check("wrp_pc", pc, 32'h0);
    check("wrp_addr", {22'b0, imem_address}, 32'h0);

    // reset in the middle of a busy fetch
    tick(); tick();
    check("mr_pc4", pc, 32'h4);
    imem_busywait = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("mr_pc", pc, 32'h0);
    check("mr_read", {31'b0, imem_read}, 32'h0);
    check("mr_valid", {31'b0, instr_valid}, 32'h0);
    check("mr_busy", {31'b0, cpu_busywait}, 32'h1);
    reset = 1'b0;
    imem_busywait = 1'b0;
    tick();
    check("mr_late_instr", instruction, 32'h0);
    check("mr_late_valid", {31'b0, instr_valid}, 32'h0);
    check("mr_fread", {31'b0, imem_read}, 32'h1);
    check("mr_fpc", pc, 32'h0);
    tick();
    check("mr_instr", instruction, 32'h0004_0005);

    // stuck memory: timeout after 64 busy FETCH cycles when enabled
    tick();
    check("to_pc", pc, 32'h4);
    imem_busywait = 1'b1;
    repeat (63) tick();
    check("to63_err", {31'b0, fetch_err}, 32'h0);
    check("to63_read", {31'b0, imem_read}, 32'h1);
    tick();
`ifdef IFETCH_TIMEOUT_EN
    check("to64_err", {31'b0, fetch_err}, 32'h1);
    check("to64_read", {31'b0, imem_read}, 32'h0);
    check("to64_busy", {31'b0, cpu_busywait}, 32'h1);
    check("to64_valid", {31'b0, instr_valid}, 32'h0);
`else
    check("to64_err", {31'b0, fetch_err}, 32'h0);
    check("to64_read", {31'b0, imem_read}, 32'h1);
`endif
    repeat (3) tick();
    imem_busywait = 1'b0;
    tick();
`ifdef IFETCH_TIMEOUT_EN
    check("err_hold_err", {31'b0, fetch_err}, 32'h1);
    check("err_hold_read", {31'b0, imem_read}, 32'h0);
    check("err_hold_valid", {31'b0, instr_valid}, 32'h0);
`else
    check("noto_valid", {31'b0, instr_valid}, 32'h1);
    check("noto_instr", instruction, 32'h1000_0001);
    check("noto_err", {31'b0, fetch_err}, 32'h0);
`endif
    reset = 1'b1;
    tick();
    check("clr_err", {31'b0, fetch_err}, 32'h0);
    check("clr_read", {31'b0, imem_read}, 32'h0);
    check("clr_pc", pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
